o_star_accum_stage: RTL and testbench

- Downstream consumer of the two expmul stages in the online-softmax datapath.
- Joins the rescaled running output exp(m_old−m_new)·O* with the newly scaled value row exp(s−m_new)·V.
- Adds the two element-wise into the O* accumulator and feeds O* back to the rescaling expmul.
- After SEQ_LEN key/value rows, emits the finished O* vector downstream. The last element carries the running denominator l.

---
 rtl/o_star_accum_stage_pkg.sv | 21 ++
 rtl/q_sat_add.sv | 24 ++
 rtl/o_star_accum_stage.sv | 140 ++++++++++++++
 tb/tb_o_star_accum_stage.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/o_star_accum_stage_pkg.sv
// Shared types and constants for the online-softmax O* accumulator stage.
package o_star_accum_stage_pkg;

  localparam int unsigned MAX_SEQ_LENGTH    = 64;
  localparam int unsigned MAX_EMBEDDING_DIM = 64;
  localparam int unsigned Q9_17_W           = 26;

  // Q9.17 signed fixed-point element
  typedef logic signed [Q9_17_W-1:0] q9_17_t;

  localparam q9_17_t Q9_17_ONE = 26'h0020000;

  // Embedding elements plus the trailing denominator element
  typedef q9_17_t [MAX_EMBEDDING_DIM:0] star_vector_t;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } o_star_accum_state_t;

endpackage

// File: rtl/q_sat_add.sv
// Single-element signed add with overflow detect and optional saturation.
module q_sat_add #(
  parameter int unsigned W   = 26,
  parameter bit          SAT = 1'b0
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] wide;

  // Add at W+1 bits; clamp toward the sign of the true result when saturating
  always_comb begin
    wide = {a[W-1], a} + {b[W-1], b};
    ovf  = wide[W] ^ wide[W-1];
    sum  = wide[W-1:0];
    if (SAT && ovf) begin
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/o_star_accum_stage.sv
// O* accumulator for the online-softmax datapath: joins the rescaled O*
// and the scaled V row, stores their sum, feeds it back, and emits the
// finished vector (denominator l in the last element) after SEQ_LEN rows.
// Optional saturation and sticky sat_flag: O_STAR_ACCUM_SATURATE_EN.
module o_star_accum_stage
  import o_star_accum_stage_pkg::*;
#(
  parameter int unsigned SEQ_LEN = MAX_SEQ_LENGTH,
  parameter int unsigned VEC_LEN = MAX_EMBEDDING_DIM + 1,
  parameter int unsigned ELEM_W  = 26,
  localparam int unsigned VW     = VEC_LEN * ELEM_W,
  localparam int unsigned CNT_W  = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            vld_v_in,
  output logic            rdy_v_out,
  input  logic [VW-1:0]   v_in,
  input  logic            vld_o_in,
  output logic            rdy_o_out,
  input  logic [VW-1:0]   o_in,
  output logic [VW-1:0]   o_star_fb,
  output logic            vld_out,
  input  logic            rdy_in,
  output logic [VW-1:0]   o_out,
`ifdef O_STAR_ACCUM_SATURATE_EN
  output logic            sat_flag,
`endif
  output logic [CNT_W-1:0] row_count
);

`ifdef O_STAR_ACCUM_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  o_star_accum_state_t state_q, state_d;
  logic [VW-1:0]    acc_q, acc_d;
  logic [VW-1:0]    o_out_q, o_out_d;
  logic             vld_q, vld_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             sat_q, sat_d;

  logic [VW-1:0]      sum_c;
  logic [VEC_LEN-1:0] ovf_c;
  logic               stage_rdy;
  logic               accept;
  logic               last_row;
  logic               drain_hs;

  // Element-wise o_in + v_in
  for (genvar i = 0; i < int'(VEC_LEN); i++) begin : g_add
    q_sat_add #(
      .W   (ELEM_W),
      .SAT (SAT_EN)
    ) u_add (
      .a   (o_in[i*ELEM_W +: ELEM_W]),
      .b   (v_in[i*ELEM_W +: ELEM_W]),
      .sum (sum_c[i*ELEM_W +: ELEM_W]),
      .ovf (ovf_c[i])
    );
  end

  // Each ready depends only on the other stream's valid
  assign stage_rdy = (state_q == ACCUM);
  assign rdy_v_out = stage_rdy & vld_o_in;
  assign rdy_o_out = stage_rdy & vld_v_in;
  assign accept    = stage_rdy & vld_v_in & vld_o_in;
  assign last_row  = (row_q == CNT_W'(SEQ_LEN - 1));
  assign drain_hs  = (state_q == DRAIN) & vld_q & rdy_in;

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    o_out_d = o_out_q;
    vld_d   = vld_q;
    row_d   = row_q;
    sat_d   = sat_q;
    case (state_q)
      ACCUM: begin
        if (accept) begin
          sat_d = sat_q | (SAT_EN & (|ovf_c));
          if (last_row) begin
            o_out_d = sum_c;
            acc_d   = '0;
            row_d   = '0;
            vld_d   = 1'b1;
            state_d = DRAIN;
          end else begin
            acc_d = sum_c;
            row_d = row_q + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_hs) begin
          vld_d   = 1'b0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      o_out_q <= '0;
      vld_q   <= 1'b0;
      row_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      o_out_q <= o_out_d;
      vld_q   <= vld_d;
      row_q   <= row_d;
      sat_q   <= sat_d;
    end
  end

  assign o_star_fb = acc_q;
  assign o_out     = o_out_q;
  assign vld_out   = vld_q;
  assign row_count = row_q;

`ifdef O_STAR_ACCUM_SATURATE_EN
  assign sat_flag = sat_q;
`else
  // Wrap mode has no flag output; overflow and flag state go nowhere
  logic unused_sat;
  assign unused_sat = sat_q;
`endif

endmodule

// File: tb/tb_o_star_accum_stage.sv
// Directed bench for o_star_accum_stage (SEQ_LEN=4, VEC_LEN=2, ELEM_W=26).
module tb_o_star_accum_stage;
  import o_star_accum_stage_pkg::*;

  localparam int unsigned SEQ_LEN = 4;
  localparam int unsigned VEC_LEN = 2;
  localparam int unsigned ELEM_W  = 26;
  localparam int unsigned VW      = VEC_LEN * ELEM_W;
  localparam int unsigned CNT_W   = 2;

  logic             clk;
  logic             rst;
  logic             vld_v_in, vld_o_in, rdy_in;
  logic             rdy_v_out, rdy_o_out, vld_out;
  logic [VW-1:0]    v_in, o_in, o_star_fb, o_out;
  logic [CNT_W-1:0] row_count;
`ifdef O_STAR_ACCUM_SATURATE_EN
  logic             sat_flag;
`endif

  int n_vec;
  int n_err;

  o_star_accum_stage #(
    .SEQ_LEN (SEQ_LEN),
    .VEC_LEN (VEC_LEN),
    .ELEM_W  (ELEM_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .vld_v_in  (vld_v_in),
    .rdy_v_out (rdy_v_out),
    .v_in      (v_in),
    .vld_o_in  (vld_o_in),
    .rdy_o_out (rdy_o_out),
    .o_in      (o_in),
    .o_star_fb (o_star_fb),
    .vld_out   (vld_out),
    .rdy_in    (rdy_in),
    .o_out     (o_out),
`ifdef O_STAR_ACCUM_SATURATE_EN
    .sat_flag  (sat_flag),
`endif
    .row_count (row_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One row presented for one cycle; returns at the negedge after the accepting edge
  task automatic apply_row(input logic [VW-1:0] o, input logic [VW-1:0] v);
    @(negedge clk);
    vld_v_in = 1'b1; vld_o_in = 1'b1; o_in = o; v_in = v;
    @(negedge clk);
    vld_v_in = 1'b0; vld_o_in = 1'b0;
  endtask

  // Complete the output handshake and confirm the stage returns to ACCUM
  task automatic drain(input string tag);
    rdy_in = 1'b1;
    @(negedge clk);
    rdy_in = 1'b0;
    chk(tag, 64'(vld_out), 64'd0);
  endtask

  logic [VW-1:0] two, four, exp_v, hold;
  logic [ELEM_W-1:0] e1;

  initial begin
    n_vec = 0; n_err = 0;
    vld_v_in = 0; vld_o_in = 0; rdy_in = 0; v_in = '0; o_in = '0;
    e1 = Q9_17_ONE;
    two  = {e1, e1};
    four = {26'h0040000, 26'h0040000};
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_fb",   64'(o_star_fb), 64'd0);
    chk("rst_oout", 64'(o_out),     64'd0);
    chk("rst_vld",  64'(vld_out),   64'd0);
    chk("rst_row",  64'(row_count), 64'd0);
    @(negedge clk); rst = 1'b1;

    // Overridden o_in: each row stores exactly o_in + v_in
    for (int k = 0; k < 3; k++) begin
      apply_row(two, two);
      chk("t1_fb",  64'(o_star_fb), 64'(four));
      chk("t1_row", 64'(row_count), 64'(k + 1));
      chk("t1_vld", 64'(vld_out),   64'd0);
    end
    apply_row(two, two);
    chk("t1_vld_fin", 64'(vld_out),   64'd1);
    chk("t1_oout",    64'(o_out),     64'(four));
    chk("t1_row_fin", 64'(row_count), 64'd0);
    chk("t1_fb_clr",  64'(o_star_fb), 64'd0);
    drain("t1_drain");

    // Feedback loop: O* grows by one each row
    for (int k = 0; k < 3; k++) begin
      apply_row(o_star_fb, two);
      exp_v = {26'(26'h20000 * (k + 1)), 26'(26'h20000 * (k + 1))};
      chk("t2_fb", 64'(o_star_fb), 64'(exp_v));
    end
    apply_row(o_star_fb, two);
    chk("t2_oout", 64'(o_out),     64'({26'h80000, 26'h80000}));
    chk("t2_fb0",  64'(o_star_fb), 64'd0);

    // Hold output with rdy_in low while both valids are offered
    hold = o_out;
    vld_v_in = 1'b1; vld_o_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4_oout_hold", 64'(o_out),     64'(hold));
      chk("t4_vld_hold",  64'(vld_out),   64'd1);
      chk("t4_rdyv",      64'(rdy_v_out), 64'd0);
      chk("t4_rdyo",      64'(rdy_o_out), 64'd0);
      chk("t4_row",       64'(row_count), 64'd0);
    end
    rdy_in = 1'b1;
    @(negedge clk);
    rdy_in = 1'b0;
    chk("t4_vld_drop", 64'(vld_out),   64'd0);
    chk("t4_rdyv_ret", 64'(rdy_v_out), 64'd1);
    chk("t4_rdyo_ret", 64'(rdy_o_out), 64'd1);
    vld_v_in = 1'b0; vld_o_in = 1'b0;

    // Lone V valid is never consumed
    o_in = {26'h10, 26'h10}; v_in = {26'h5, 26'h5};
    vld_v_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t3_rdyv", 64'(rdy_v_out), 64'd0);
      chk("t3_rdyo", 64'(rdy_o_out), 64'd1);
      chk("t3_row",  64'(row_count), 64'd0);
    end
    vld_o_in = 1'b1;
    #1 chk("t3_rdyv_up", 64'(rdy_v_out), 64'd1);
    @(negedge clk);
    vld_v_in = 1'b0; vld_o_in = 1'b0;
    chk("t3_row_acc", 64'(row_count), 64'd1);
    chk("t3_fb",      64'(o_star_fb), 64'({26'h15, 26'h15}));

    // Asynchronous reset mid-query discards partial O*
    apply_row(two, two);
    chk("t5_row_pre", 64'(row_count), 64'd2);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("t5_fb",   64'(o_star_fb), 64'd0);
    chk("t5_row",  64'(row_count), 64'd0);
    chk("t5_oout", 64'(o_out),     64'd0);
    chk("t5_vld",  64'(vld_out),   64'd0);
    @(negedge clk); rst = 1'b1;
    exp_v = {26'h0000001, 26'h0000300};
    for (int k = 0; k < 3; k++) begin
      apply_row({26'h3FFFFFF, 26'h100}, {26'h0000002, 26'h200});
      chk("t5_fb_row", 64'(o_star_fb), 64'(exp_v));
      chk("t5_vld_mid", 64'(vld_out),  64'd0);
    end
    apply_row({26'h3FFFFFF, 26'h100}, {26'h0000002, 26'h200});
    chk("t5_vld_fin", 64'(vld_out), 64'd1);
    chk("t5_oout_fin", 64'(o_out),  64'(exp_v));
    drain("t5_drain");

    // Overflow on both elements: positive and negative
`ifdef O_STAR_ACCUM_SATURATE_EN
    chk("t6_flag0", 64'(sat_flag), 64'd0);
    exp_v = {26'h1FFFFFF, 26'h2000000};
`else
    exp_v = {26'h3FFFFFE, 26'h0000000};
`endif
    apply_row({26'h1FFFFFF, 26'h2000000}, {26'h1FFFFFF, 26'h2000000});
    chk("t6_fb_ovf", 64'(o_star_fb), 64'(exp_v));
`ifdef O_STAR_ACCUM_SATURATE_EN
    chk("t6_flag1", 64'(sat_flag), 64'd1);
`endif
    for (int k = 0; k < 3; k++) apply_row('0, '0);
    chk("t6_vld_fin", 64'(vld_out), 64'd1);
    chk("t6_oout",    64'(o_out),   64'd0);
`ifdef O_STAR_ACCUM_SATURATE_EN
    chk("t6_flag_held", 64'(sat_flag), 64'd1);
`endif
    drain("t6_drain");
`ifdef O_STAR_ACCUM_SATURATE_EN
    chk("t6_flag_clr", 64'(sat_flag), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
